// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch sequencer.
//
// Holds the PC and issues one fetch request per PC value. The PC moves
// ("advances") only at an instruction boundary signalled by stall=0.
// Redirects arriving between advances are parked in a pending register
// (last one wins) and consumed by the next advance.
//
// Optional feature: define PC_TRAP_EN to divert misaligned targets
// (target[1:0] != 0) to TRAP_VEC and raise a one-cycle trap pulse.
// Without it, targets load unmodified and trap is tied low.
module pc_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [31:0]     instret,
    output logic            trap
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            pend_vld_q, pend_vld_d;
    logic            adv_pend_q, adv_pend_d;
    logic            req_q, req_d;
    logic [31:0]     instret_q, instret_d;

    logic            advance;
    logic [XLEN-1:0] sel_tgt;
    logic [XLEN-1:0] next_pc;

    // Sequential increment wraps naturally at the top of the address space.
    assign pc_plus4  = pc_q + XLEN'(4);

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign imem_req  = req_q;
    assign instret   = instret_q;

    // Target priority: same-cycle redirect, then parked redirect, then pc+4.
    always_comb begin
        sel_tgt = pc_plus4;
        if (redirect_valid) begin
            sel_tgt = redirect_target;
        end else if (pend_vld_q) begin
            sel_tgt = pend_tgt_q;
        end
    end

`ifdef PC_TRAP_EN
    logic misaligned;

    // Misaligned targets are replaced by the trap vector; trap flags the
    // cycle in which such an advance is taken.
    assign misaligned = (sel_tgt[1:0] != 2'b00);
    assign next_pc    = misaligned ? TRAP_VEC : sel_tgt;
    assign trap       = advance & misaligned;
`else
    assign next_pc    = sel_tgt;
    assign trap       = 1'b0;
`endif

    // An advance happens at a boundary in HOLD, or on the grant in FETCH
    // when a boundary was seen earlier in the fetch or is present now.
    always_comb begin
        advance = 1'b0;
        case (state_q)
            FETCH:   advance = imem_gnt & (adv_pend_q | ~stall);
            HOLD:    advance = ~stall;
            default: advance = 1'b0;
        endcase
    end

    // Next-state logic for the sequencer, PC, counters and pending registers.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_vld_d = pend_vld_q;
        adv_pend_d = adv_pend_q;
        instret_d  = instret_q;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_gnt) begin
                    // With an advance the new address is requested right away.
                    state_d = advance ? FETCH : HOLD;
                end else if (!stall) begin
                    // Only one boundary is remembered per outstanding fetch.
                    adv_pend_d = 1'b1;
                end
            end
            HOLD: begin
                if (advance) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (advance) begin
            pc_d       = next_pc;
            instret_d  = instret_q + 32'd1;
            pend_vld_d = 1'b0;
            adv_pend_d = 1'b0;
        end else if (redirect_valid) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = redirect_target;
        end

        // Request is a registered decode of the next state, so it rises the
        // cycle after the PC update and drops at once on reset.
        req_d = (state_d == FETCH);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            pend_vld_q <= 1'b0;
            adv_pend_q <= 1'b0;
            req_q      <= 1'b0;
            instret_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_vld_q <= pend_vld_d;
            adv_pend_q <= adv_pend_d;
            req_q      <= req_d;
            instret_q  <= instret_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit with a cycle model of
// the fetch/advance rules and a negedge compare process.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instret;
    logic        trap;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .instret         (instret),
        .trap            (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: booted / request-open / boundary-owed, plus pending redirect.
    bit          m_booted;
    bit          m_open;
    bit          m_owe;
    bit          m_pv;
    logic [31:0] m_pt;
    logic [31:0] m_pc;
    logic [31:0] m_ir;

    function automatic void m_decide(output bit adv, output logic [31:0] tgt, output bit mis);
        adv = 1'b0;
        if (m_booted) begin
            if (m_open) adv = imem_gnt && (m_owe || !stall);
            else        adv = !stall;
        end
        if (redirect_valid) tgt = redirect_target;
        else if (m_pv)      tgt = m_pt;
        else                tgt = m_pc + 32'd4;
        mis = (tgt[1:0] != 2'b00);
`ifdef PC_TRAP_EN
        if (mis) tgt = 32'h0000_0100;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin : model_p
        bit          adv;
        bit          mis;
        logic [31:0] tgt;
        if (!rst) begin
            m_booted <= 1'b0;
            m_open   <= 1'b0;
            m_owe    <= 1'b0;
            m_pv     <= 1'b0;
            m_pt     <= 32'd0;
            m_pc     <= 32'd0;
            m_ir     <= 32'd0;
        end else begin
            m_decide(adv, tgt, mis);
            if (adv) begin
                m_pc   <= tgt;
                m_ir   <= m_ir + 32'd1;
                m_pv   <= 1'b0;
                m_owe  <= 1'b0;
                m_open <= 1'b1;
            end else begin
                if (redirect_valid) begin
                    m_pv <= 1'b1;
                    m_pt <= redirect_target;
                end
                if (!m_booted) m_open <= 1'b1;
                else if (m_open) begin
                    if (imem_gnt)    m_open <= 1'b0;
                    else if (!stall) m_owe  <= 1'b1;
                end
            end
            m_booted <= 1'b1;
        end
    end

    // Fetched-address log, sampled where the DUT will see the grant.
    logic [31:0] fq[$];

    always @(negedge clk) begin : cmp_p
        bit          adv;
        bit          mis;
        logic [31:0] tgt;
        logic        texp;
        m_decide(adv, tgt, mis);
        texp = 1'b0;
`ifdef PC_TRAP_EN
        texp = rst && adv && mis;
`endif
        chk("m_req",     {31'd0, imem_req}, {31'd0, m_open});
        chk("m_addr",    imem_addr, m_pc);
        chk("m_pc",      pc, m_pc);
        chk("m_pc4",     pc_plus4, m_pc + 32'd4);
        chk("m_instret", instret, m_ir);
        chk("m_trap",    {31'd0, trap}, {31'd0, texp});
        if (rst && imem_req && imem_gnt) fq.push_back(imem_addr);
    end

    // Drive inputs for the coming edge, then return just after it.
    task automatic cyc(input bit st, input bit rv, input logic [31:0] rt, input bit g);
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        imem_gnt        = g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b0;
        stall           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        imem_gnt        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc",      pc, 32'd0);
        chk("rst_req",     {31'd0, imem_req}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_trap",    {31'd0, trap}, 32'd0);
        #2 rst = 1'b1;

        // Sequential fetch with grant always high, boundary every 6th cycle.
        begin : seq_blk
            bit done = 1'b0;
            for (int c = 1; c <= 100 && !done; c++) begin
                cyc((c % 6) != 0, 1'b0, 32'd0, 1'b1);
                if (instret == 32'd3) done = 1'b1;
            end
            chk("seq_done", {31'd0, done}, 32'd1);
        end
        chk("seq_count", fq.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("seq_fetch%0d", i), (i < fq.size()) ? fq[i] : 32'hdead_beef, 32'(i * 4));
        chk("seq_pc", pc, 32'h0000_000C);

        // Redirect parked in HOLD, consumed two cycles later, then cleared.
        cyc(1, 0, 32'd0, 1);
        cyc(1, 1, 32'h40, 1);
        cyc(1, 0, 32'd0, 1);
        cyc(0, 0, 32'd0, 1);
        chk("pend_pc", pc, 32'h0000_0040);
        cyc(1, 0, 32'd0, 1);
        cyc(0, 0, 32'd0, 1);
        chk("pend_clear_pc", pc, 32'h0000_0044);

        // Two redirects before one advance: the last one wins.
        cyc(1, 0, 32'd0, 1);
        cyc(1, 1, 32'h40, 1);
        cyc(1, 1, 32'h80, 1);
        cyc(0, 0, 32'd0, 0);
        chk("last_wins_pc", pc, 32'h0000_0080);

        // Grant withheld, two boundaries in FETCH: address holds, one advance.
        for (int i = 0; i < 5; i++) begin
            cyc((i % 2) == 0, 0, 32'd0, 0);
            chk("wait_addr", imem_addr, 32'h0000_0080);
            chk("wait_req",  {31'd0, imem_req}, 32'd1);
        end
        cyc(1, 0, 32'd0, 1);
        chk("gnt_adv_pc",  pc, 32'h0000_0084);
        chk("gnt_adv_req", {31'd0, imem_req}, 32'd1);
        chk("gnt_adv_ir",  instret, 32'd7);
        cyc(1, 0, 32'd0, 1);
        chk("one_adv_pc",  pc, 32'h0000_0084);
        chk("one_adv_req", {31'd0, imem_req}, 32'd0);
        chk("one_adv_ir",  instret, 32'd7);

        // Top of address space wraps to zero.
        cyc(0, 1, 32'hFFFF_FFFC, 1);
        chk("top_pc",  pc, 32'hFFFF_FFFC);
        chk("top_pc4", pc_plus4, 32'd0);
        cyc(1, 0, 32'd0, 1);
        cyc(0, 0, 32'd0, 1);
        chk("wrap_pc", pc, 32'd0);
        chk("wrap_ir", instret, 32'd9);

        // Misaligned redirect with a same-cycle advance.
        cyc(1, 0, 32'd0, 1);
        stall           = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h42;
        #1;
`ifdef PC_TRAP_EN
        chk("mis_trap", {31'd0, trap}, 32'd1);
`else
        chk("mis_trap", {31'd0, trap}, 32'd0);
`endif
        @(posedge clk);
        #1;
        stall          = 1'b1;
        redirect_valid = 1'b0;
        #1;
`ifdef PC_TRAP_EN
        chk("mis_pc", pc, 32'h0000_0100);
`else
        chk("mis_pc", pc, 32'h0000_0042);
`endif
        chk("mis_trap_after", {31'd0, trap}, 32'd0);
        chk("mis_ir", instret, 32'd10);

        // Reset in the middle of an outstanding fetch; grants during reset ignored.
        cyc(1, 0, 32'd0, 0);
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_pc",  pc, 32'd0);
        chk("async_ir",  instret, 32'd0);
        cyc(1, 0, 32'd0, 1);
        cyc(1, 0, 32'd0, 1);
        chk("rst_gnt_req", {31'd0, imem_req}, 32'd0);
        chk("rst_gnt_pc",  pc, 32'd0);
        #2 rst = 1'b1;
        cyc(1, 0, 32'd0, 1);
        chk("boot_req",  {31'd0, imem_req}, 32'd1);
        chk("boot_addr", imem_addr, 32'd0);
        cyc(1, 0, 32'd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of PC, target and fetch address.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, PC loaded on misaligned redirect; used only under PC_TRAP_EN.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-006 SHALL have port stall  input  1  from the cycle sequencer; 0 = instruction boundary, PC may advance.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 SHALL have port redirect_target  input  XLEN  destination of the redirect.
REQ-009 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-010 SHALL have port imem_addr  output  XLEN  fetch address, equal to pc.
REQ-011 SHALL have port imem_gnt  input  1  memory accepted the request this cycle.
REQ-012 SHALL have port pc  output  XLEN  current program counter.
REQ-013 SHALL have port pc_plus4  output  XLEN  pc + 4, combinational, modulo 2^XLEN.
REQ-014 SHALL have port instret  output  32  count of retired PC advances.
REQ-015 SHALL have port trap  output  1  one-cycle pulse on misaligned redirect; tied 0 without PC_TRAP_EN.

Function
REQ-016 SHALL implement states BOOT, FETCH, HOLD; BOOT exits to FETCH on the first clock after reset release.
REQ-017 FETCH SHALL drive imem_req=1 and stay in FETCH until imem_gnt=1, then go to HOLD; imem_addr SHALL stay stable while imem_req=1 and no grant is received.
REQ-018 HOLD SHALL drive imem_req=0; on stall=0 the unit SHALL advance the PC and go to FETCH on the next edge.
REQ-019 Advance SHALL load pc with the next PC: the same-cycle redirect_target if redirect_valid=1, else the pending target if one is held, else pc_plus4.
REQ-020 A redirect_valid=1 in a cycle without an advance SHALL be captured into a pending register; a later redirect before the advance SHALL overwrite it, so the last redirect wins.
REQ-021 The pending register SHALL clear on the advance that consumes it.
REQ-022 If stall=0 occurs in FETCH before imem_gnt, a single advance_pending flag SHALL set; the advance SHALL execute on the grant cycle, going FETCH->FETCH with a new address. Further stall=0 cycles before the grant SHALL NOT queue additional advances.
REQ-023 instret SHALL increment by 1 on every advance and wrap from 2^32-1 to 0.
REQ-024 pc + 4 SHALL wrap modulo 2^XLEN; the top address plus 4 SHALL give 0.
REQ-025 Fetch latency: imem_req SHALL assert the cycle after the PC update.

Reset
REQ-026 While rst=0, the unit SHALL set state=BOOT, pc=RESET_PC, imem_req=0, instret=0, trap=0, and clear both pending register and advance_pending, asynchronously.
REQ-027 Reset asserted mid-fetch SHALL drop imem_req immediately; any grant arriving during reset SHALL be ignored.

Configuration
REQ-028 With macro PC_TRAP_EN defined, an advance whose selected target has target[1:0]!=0 SHALL load TRAP_VEC and pulse trap=1 for exactly the advance cycle; instret SHALL still increment.
REQ-029 Without PC_TRAP_EN, targets SHALL be loaded unmodified, trap SHALL be constant 0, and no TRAP_VEC logic SHALL exist.

Verification
REQ-030 Reset release with RESET_PC=0 and imem_gnt held 1, stall=0 every 6th cycle -> addresses 0x0, 0x4, 0x8 fetched in order, and instret=3 after three advances.
REQ-031 redirect_valid=1 to 0x40 during HOLD with stall=1, then stall=0 two cycles later -> pc=0x40, and the pending register is clear afterward.
REQ-032 Redirects to 0x40 and then 0x80 before the same advance -> pc=0x80.
REQ-033 imem_gnt held 0 for 5 cycles with stall=0 pulsed twice in FETCH -> imem_addr stable, and exactly one advance on the grant.
REQ-034 pc=0xFFFF_FFFC, advance with no redirect -> pc=0x0.
REQ-035 With PC_TRAP_EN defined, redirect to 0x42 -> pc=0x100 and trap high for 1 cycle; without it -> pc=0x42 and trap=0.
